// File: rtl/image_processor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// image_processor: applies a 3x3 signed Q(FRAC_BITS) matrix to one RGB pixel.
// Optional build macro IMAGE_PROCESSOR_ROUND_EN selects round-half-up scaling.
// Revision: 1.0
// ----------------------------------------------------------------------------
module image_processor #(
  parameter int COEF_WIDTH = 32,
  parameter int FRAC_BITS  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [23:0]             input_rgb,
  input  logic                    input_valid,
  output logic                    input_ready,
  input  logic [9*COEF_WIDTH-1:0] comp_matrix,
  input  logic                    matrix_valid,
  output logic [23:0]             output_rgb,
  output logic                    output_valid,
  output logic                    busy
);

  localparam int PROD_W = COEF_WIDTH + 9;
  localparam int SUM_W  = PROD_W + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic signed [COEF_WIDTH-1:0] coef_q [9];
  logic        [7:0]            pix_q  [3];
  logic signed [PROD_W-1:0]     prod_q [9];
  logic signed [SUM_W-1:0]      sum_q  [3];
  logic                         accept;

  assign input_ready = (state == IDLE) && matrix_valid && !rst;
  assign accept      = input_valid && input_ready;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = MUL;
      MUL:     state_next = ADD;
      ADD:     state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Both operands are widened to the product width so the multiply is signed.
  function automatic logic signed [PROD_W-1:0] mul(input logic signed [COEF_WIDTH-1:0] c,
                                                   input logic [7:0] p);
    logic signed [PROD_W-1:0] a;
    logic signed [PROD_W-1:0] b;
    a = {{(PROD_W-COEF_WIDTH){c[COEF_WIDTH-1]}}, c};
    b = {{(PROD_W-8){1'b0}}, p};
    return a * b;
  endfunction

  function automatic logic signed [SUM_W-1:0] ext(input logic signed [PROD_W-1:0] p);
    return {{(SUM_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  function automatic logic [7:0] scale_clamp(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W:0] t;
    t = {s[SUM_W-1], s};
`ifdef IMAGE_PROCESSOR_ROUND_EN
    t = t + {{(SUM_W+1-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
`else
    t = t;
`endif
    t = t >>> FRAC_BITS;
    if (t[SUM_W])           return 8'h00;
    else if (|t[SUM_W-1:8]) return 8'hFF;
    else                    return t[7:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        coef_q[i] <= '0;
        prod_q[i] <= '0;
      end
      for (int i = 0; i < 3; i++) begin
        pix_q[i] <= '0;
        sum_q[i] <= '0;
      end
      output_rgb   <= '0;
      output_valid <= 1'b0;
    end else begin
      output_valid <= 1'b0;
      if (accept) begin
        for (int i = 0; i < 9; i++)
          coef_q[i] <= comp_matrix[i*COEF_WIDTH +: COEF_WIDTH];
        pix_q[0] <= input_rgb[23:16];
        pix_q[1] <= input_rgb[15:8];
        pix_q[2] <= input_rgb[7:0];
      end
      if (state == MUL) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            prod_q[3*r+c] <= mul(coef_q[3*r+c], pix_q[c]);
      end
      if (state == ADD) begin
        for (int r = 0; r < 3; r++)
          sum_q[r] <= ext(prod_q[3*r]) + ext(prod_q[3*r+1]) + ext(prod_q[3*r+2]);
      end
      if (state == OUT) begin
        output_rgb   <= {scale_clamp(sum_q[0]), scale_clamp(sum_q[1]), scale_clamp(sum_q[2])};
        output_valid <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_image_processor.sv
`default_nettype none
// Directed self-checking bench for image_processor.
module tb_image_processor;

  logic         clk = 1'b0;
  logic         rst;
  logic [23:0]  input_rgb;
  logic         input_valid;
  logic         input_ready;
  logic [287:0] comp_matrix;
  logic         matrix_valid;
  logic [23:0]  output_rgb;
  logic         output_valid;
  logic         busy;

  int total = 0;
  int bad   = 0;

  image_processor dut (
    .clk          (clk),
    .rst          (rst),
    .input_rgb    (input_rgb),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .comp_matrix  (comp_matrix),
    .matrix_valid (matrix_valid),
    .output_rgb   (output_rgb),
    .output_valid (output_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [287:0] mk(input logic [31:0] m00, m01, m02,
                                      input logic [31:0] m10, m11, m12,
                                      input logic [31:0] m20, m21, m22);
    return {m22, m21, m20, m12, m11, m10, m02, m01, m00};
  endfunction

  // Called at a negedge with the DUT idle; returns at the output_valid negedge.
  task automatic run_pixel(input string tag, input logic [287:0] m, input logic [287:0] m_after,
                           input logic [23:0] pix, input logic [23:0] exp);
    comp_matrix  = m;
    matrix_valid = 1'b1;
    input_rgb    = pix;
    input_valid  = 1'b1;
    #1 check({tag, " ready"}, 32'(input_ready), 32'd1);
    @(negedge clk);
    input_valid  = 1'b0;
    comp_matrix  = m_after;
    input_rgb    = ~pix;
    check({tag, " busy1"}, 32'(busy), 32'd1);
    check({tag, " ov1"}, 32'(output_valid), 32'd0);
    @(negedge clk);
    check({tag, " busy2"}, 32'(busy), 32'd1);
    @(negedge clk);
    check({tag, " busy3"}, 32'(busy), 32'd1);
    check({tag, " ov3"}, 32'(output_valid), 32'd0);
    @(negedge clk);
    check({tag, " ov"}, 32'(output_valid), 32'd1);
    check({tag, " busy_lo"}, 32'(busy), 32'd0);
    check({tag, " rgb"}, 32'(output_rgb), 32'(exp));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [287:0] ident;
    logic [287:0] zero;
    logic [23:0]  half_exp;
    ident = mk(32'h10000, 0, 0, 0, 32'h10000, 0, 0, 0, 32'h10000);
    zero  = '0;
`ifdef IMAGE_PROCESSOR_ROUND_EN
    half_exp = 24'h800000;
`else
    half_exp = 24'h7F0000;
`endif

    rst = 1'b1; input_rgb = '0; input_valid = 1'b0; comp_matrix = '0; matrix_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst rgb", 32'(output_rgb), 32'd0);
    check("rst ov", 32'(output_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst ready", 32'(input_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: each new pixel is offered in the previous output_valid cycle.
    run_pixel("id_r", ident, ident, 24'hFF0000, 24'hFF0000);
    run_pixel("id_g", ident, ident, 24'h00FF00, 24'h00FF00);
    run_pixel("id_b", ident, ident, 24'h0000FF, 24'h0000FF);
    @(negedge clk);
    check("pulse", 32'(output_valid), 32'd0);

    run_pixel("perm", mk(0, 32'h10000, 0, 0, 0, 32'h10000, 32'h10000, 0, 0), zero,
              24'h123456, 24'h345612);
    run_pixel("diag1", mk(32'hC000, 0, 0, 0, 32'hE000, 0, 0, 0, 32'h14000), zero,
              24'hFFFFFF, 24'hBFDFFF);
    run_pixel("diag2", mk(32'h14000, 0, 0, 0, 32'h11000, 0, 0, 0, 32'hC000), zero,
              24'hFFFFFF, 24'hFFFFBF);
    run_pixel("half", mk(32'h8000, 0, 0, 0, 0, 0, 0, 0, 0), zero, 24'hFF0000, half_exp);
    run_pixel("neg", mk(32'hFFFF0000, 0, 0, 0, 0, 0, 0, 0, 0), zero, 24'hFF0000, 24'h000000);
    run_pixel("latch", ident, zero, 24'h5A3CC3, 24'h5A3CC3);

    @(negedge clk);
    matrix_valid = 1'b0;
    input_rgb    = 24'hABCDEF;
    input_valid  = 1'b1;
    #1 check("nomv ready", 32'(input_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("nomv busy", 32'(busy), 32'd0);
      check("nomv ov", 32'(output_valid), 32'd0);
    end
    check("nomv hold", 32'(output_rgb), 32'h5A3CC3);
    input_valid = 1'b0;

    matrix_valid = 1'b1;
    comp_matrix  = ident;
    input_rgb    = 24'h112233;
    input_valid  = 1'b1;
    @(negedge clk);
    input_valid = 1'b0;
    check("abort busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort rgb", 32'(output_rgb), 32'd0);
    check("abort busy_lo", 32'(busy), 32'd0);
    check("abort ready", 32'(input_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("abort ready_back", 32'(input_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort ov", 32'(output_valid), 32'd0);
      check("abort idle", 32'(busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
